// File: rtl/score_keeper.sv
// Game-state counter: two-digit BCD score fed from a one-point-per-clock queue,
// lives with a once-per-game tens-digit bonus, and the IDLE/PLAY/OVER game FSM.
module score_keeper #(
    parameter int unsigned START_LIVES = 3,
    parameter int unsigned MAX_LIVES   = 9,
    parameter int unsigned HIT_POINTS  = 1,
    parameter int unsigned PENDING_W   = 4,
    parameter int unsigned BONUS_TENS  = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       new_game,
    input  logic       brick_hit,
    input  logic       ball_lost,
    output logic [3:0] score0,
    output logic [3:0] score1,
    output logic [3:0] lives,
    output logic       game_over,
    output logic       busy
);

    localparam int unsigned PEND_MAX = (1 << PENDING_W) - 1;
    localparam int unsigned SUM_W    = PENDING_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_OVER} state_t;

    state_t                 r_state;
    logic [3:0]             r_score0;
    logic [3:0]             r_score1;
    logic [3:0]             r_lives;
    logic [PENDING_W-1:0]   r_pending;
    logic                   r_bonus_given;
    logic                   r_game_over;
    logic                   r_busy;

    logic                   w_play;
    logic                   w_start;
    logic                   w_step;
    logic                   w_carry;
    logic                   w_bonus;
    logic [SUM_W-1:0]       w_pend_sum;
    logic [PENDING_W-1:0]   w_pend_next;
    logic [3:0]             w_s0_next;
    logic [3:0]             w_s1_next;
    logic [4:0]             w_lives_sum;
    logic [3:0]             w_lives_next;
    state_t                 w_state_next;

    // Next-state values for queue, BCD score, lives and game state
    always_comb begin
        w_play       = (r_state == S_PLAY);
        w_start      = new_game && (r_state != S_PLAY);
        w_step       = (r_pending != '0);
        w_carry      = 1'b0;
        w_s0_next    = r_score0;
        w_s1_next    = r_score1;
        w_state_next = r_state;

        w_pend_sum = SUM_W'(r_pending) - SUM_W'(w_step)
                   + ((brick_hit && w_play) ? SUM_W'(HIT_POINTS) : SUM_W'(0));
        w_pend_next = (w_pend_sum > SUM_W'(PEND_MAX)) ? PENDING_W'(PEND_MAX)
                                                      : w_pend_sum[PENDING_W-1:0];

        if (w_step) begin
            if (r_score0 == 4'd9) begin
                w_s0_next = 4'd0;
                w_carry   = 1'b1;
                w_s1_next = (r_score1 == 4'd9) ? 4'd0 : r_score1 + 4'd1;
            end else begin
                w_s0_next = r_score0 + 4'd1;
            end
        end

        w_bonus = w_carry && (w_s1_next == 4'(BONUS_TENS)) && !r_bonus_given;

        // Bonus is added before the loss so loss+bonus at one life nets to zero
        w_lives_sum = {1'b0, r_lives} + 5'(w_bonus);
        if (ball_lost && w_play && (w_lives_sum != 5'd0))
            w_lives_sum = w_lives_sum - 5'd1;
        w_lives_next = (w_lives_sum > 5'(MAX_LIVES)) ? 4'(MAX_LIVES) : w_lives_sum[3:0];

        if (w_play && (w_lives_next == 4'd0))
            w_state_next = S_OVER;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_score0      <= 4'd0;
            r_score1      <= 4'd0;
            r_lives       <= 4'(START_LIVES);
            r_pending     <= '0;
            r_bonus_given <= 1'b0;
            r_game_over   <= 1'b0;
            r_busy        <= 1'b0;
        end else if (w_start) begin
            r_state       <= S_PLAY;
            r_score0      <= 4'd0;
            r_score1      <= 4'd0;
            r_lives       <= 4'(START_LIVES);
            r_pending     <= '0;
            r_bonus_given <= 1'b0;
            r_game_over   <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_score0      <= w_s0_next;
            r_score1      <= w_s1_next;
            r_lives       <= w_lives_next;
            r_pending     <= w_pend_next;
            r_bonus_given <= r_bonus_given | w_bonus;
            r_game_over   <= (w_state_next == S_OVER);
            r_busy        <= (w_pend_next != '0);
        end
    end

    assign score0    = r_score0;
    assign score1    = r_score1;
    assign lives     = r_lives;
    assign game_over = r_game_over;
    assign busy      = r_busy;

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper (HIT_POINTS=3): a vector table for the basic
// score/queue flow plus hand sequences for saturation, bonus, wrap, game over, reset.
module tb_score_keeper;

    logic       clk = 1'b0;
    logic       reset;
    logic       new_game;
    logic       brick_hit;
    logic       ball_lost;
    logic [3:0] score0;
    logic [3:0] score1;
    logic [3:0] lives;
    logic       game_over;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    score_keeper #(
        .START_LIVES(3), .MAX_LIVES(9), .HIT_POINTS(3), .PENDING_W(4), .BONUS_TENS(5)
    ) dut (
        .clk(clk), .reset(reset), .new_game(new_game), .brick_hit(brick_hit),
        .ball_lost(ball_lost), .score0(score0), .score1(score1), .lives(lives),
        .game_over(game_over), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       ng;
        logic       hit;
        logic       lost;
        logic [3:0] s1;
        logic [3:0] s0;
        logic [3:0] lv;
        logic       go;
        logic       bz;
    } vec_t;

    vec_t vecs[14];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ng, input logic hit, input logic lost);
        new_game  = ng;
        brick_hit = hit;
        ball_lost = lost;
        tick();
        new_game  = 1'b0;
        brick_hit = 1'b0;
        ball_lost = 1'b0;
    endtask

    task automatic check_all(input string name, input logic [3:0] s1, input logic [3:0] s0,
                             input logic [3:0] lv, input logic go, input logic bz);
        n_tests++;
        if (score1 !== s1 || score0 !== s0 || lives !== lv || game_over !== go || busy !== bz) begin
            n_fail++;
            $display("FAIL %s: got score=%0h%0h lives=%0d go=%b busy=%b, want score=%0h%0h lives=%0d go=%b busy=%b",
                     name, score1, score0, lives, game_over, busy, s1, s0, lv, go, bz);
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy === 1'b1 && n < 40) begin
            tick();
            n++;
        end
        if (busy !== 1'b0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: busy still %b after 40 cycles, want 0", name, busy);
        end
    endtask

    // Each hit followed by two idle cycles keeps the queue at most 3 deep
    task automatic add_hits(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'b1, 1'b0);
            tick();
            tick();
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
    endtask

    initial begin
        new_game  = 1'b0;
        brick_hit = 1'b0;
        ball_lost = 1'b0;
        reset     = 1'b1;

        //          ng    hit   lost  s1    s0    lv    go    bz
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd3, 1'b0, 1'b0}; // hit in IDLE ignored
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd3, 1'b0, 1'b0}; // start game
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd3, 1'b0, 1'b1}; // edge N
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 4'd0, 4'd1, 4'd3, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 4'd0, 4'd2, 4'd3, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 4'd0, 4'd3, 4'd3, 1'b0, 1'b0}; // N+3
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 4'd0, 4'd3, 4'd3, 1'b0, 1'b1}; // back-to-back hits
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 4'd0, 4'd4, 4'd3, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 4'd0, 4'd5, 4'd3, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 4'd0, 4'd6, 4'd3, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 4'd0, 4'd7, 4'd3, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 4'd0, 4'd8, 4'd3, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 4'd0, 4'd9, 4'd3, 1'b0, 1'b0}; // +6 total, none lost
        vecs[13] = '{1'b1, 1'b0, 1'b0, 4'd0, 4'd9, 4'd3, 1'b0, 1'b0}; // new_game in PLAY ignored

        // Reset state
        do_reset();
        check_all("reset", 4'd0, 4'd0, 4'd3, 1'b0, 1'b0);

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].ng, vecs[i].hit, vecs[i].lost);
            check_all($sformatf("vec%0d", i), vecs[i].s1, vecs[i].s0, vecs[i].lv, vecs[i].go, vecs[i].bz);
        end

        // Flood: 10 consecutive hits; queue caps at 15, so 9 + 15 = 24 points land
        do_reset();
        drive(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 1'b0);
        check_all("flood_mid", 4'd0, 4'd9, 4'd3, 1'b0, 1'b1);
        wait_idle("flood_drain");
        check_all("flood_sat", 4'd2, 4'd4, 4'd3, 1'b0, 1'b0);

        // Bonus at 50, wrap at 99, no second bonus
        do_reset();
        drive(1'b1, 1'b0, 1'b0);
        add_hits(16);
        wait_idle("to48");
        check_all("score48", 4'd4, 4'd8, 4'd3, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        tick();
        check_all("score49", 4'd4, 4'd9, 4'd3, 1'b0, 1'b1);
        tick();
        check_all("bonus50", 4'd5, 4'd0, 4'd4, 1'b0, 1'b1);
        wait_idle("to51");
        check_all("score51", 4'd5, 4'd1, 4'd4, 1'b0, 1'b0);
        add_hits(16);
        wait_idle("to99");
        check_all("score99", 4'd9, 4'd9, 4'd4, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        tick();
        check_all("wrap00", 4'd0, 4'd0, 4'd4, 1'b0, 1'b1);
        wait_idle("to02");
        check_all("score02", 4'd0, 4'd2, 4'd4, 1'b0, 1'b0);
        add_hits(16);
        wait_idle("to50b");
        check_all("no_bonus2", 4'd5, 4'd0, 4'd4, 1'b0, 1'b0);

        // Lives to zero, inputs ignored in OVER, restart
        do_reset();
        drive(1'b1, 1'b0, 1'b0);
        add_hits(1);
        wait_idle("to03");
        drive(1'b1, 1'b0, 1'b0);
        check_all("ng_in_play", 4'd0, 4'd3, 4'd3, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        check_all("lost1", 4'd0, 4'd3, 4'd2, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        check_all("lost2", 4'd0, 4'd3, 4'd1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        check_all("lost3_over", 4'd0, 4'd3, 4'd0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b1);
        check_all("over_ignore", 4'd0, 4'd3, 4'd0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        check_all("restart", 4'd0, 4'd0, 4'd3, 1'b0, 1'b0);

        // One life: loss coincides with 49->50 bonus step
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1);
        check_all("lives1", 4'd0, 4'd0, 4'd1, 1'b0, 1'b0);
        add_hits(16);
        wait_idle("to48b");
        drive(1'b0, 1'b1, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b1);
        check_all("loss_plus_bonus", 4'd5, 4'd0, 4'd1, 1'b0, 1'b1);
        tick();
        check_all("score51b", 4'd5, 4'd1, 4'd1, 1'b0, 1'b0);

        // Async reset mid-drain clears everything without a clock edge
        drive(1'b0, 1'b1, 1'b0);
        tick();
        check_all("pre_reset", 4'd5, 4'd2, 4'd1, 1'b0, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check_all("async_reset", 4'd0, 4'd0, 4'd3, 1'b0, 1'b0);
        #1;
        reset = 1'b1;
        tick();
        tick();
        check_all("queue_dropped", 4'd0, 4'd0, 4'd3, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
